// File: rtl/spi_flash_arbiter_if.sv
// Requester, controller and status signals of the two-port SPI flash arbiter.
// master = arbiter side, slave = requesters/controller side.
interface spi_flash_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic              rq0_req;
  logic              rq0_read;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_ack;
  logic [DATA_W-1:0] rq0_rdata;
  logic              rq0_err;

  logic              rq1_req;
  logic              rq1_read;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_ack;
  logic [DATA_W-1:0] rq1_rdata;
  logic              rq1_err;

  logic              mem_cs;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              gnt_id;

  modport master (
    input  rq0_req, rq0_read, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_read, rq1_addr, rq1_wdata,
    input  mem_ready, mem_rdata,
    output rq0_ack, rq0_rdata, rq0_err,
    output rq1_ack, rq1_rdata, rq1_err,
    output mem_cs, mem_read, mem_addr, mem_wdata,
    output busy, gnt_id
  );

  modport slave (
    output rq0_req, rq0_read, rq0_addr, rq0_wdata,
    output rq1_req, rq1_read, rq1_addr, rq1_wdata,
    output mem_ready, mem_rdata,
    input  rq0_ack, rq0_rdata, rq0_err,
    input  rq1_ack, rq1_rdata, rq1_err,
    input  mem_cs, mem_read, mem_addr, mem_wdata,
    input  busy, gnt_id
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Two-port round-robin sequencer sharing one SPI flash controller.
// Define SPI_ARB_TIMEOUT_EN for the WAIT timeout with error ack.
module spi_flash_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                 clk,
  input logic                 rst,
  spi_flash_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic last_grant;
  logic gnt;
  logic gnt_nx;
  logic grant_en;
  logic finish;
  logic req0;
  logic req1;
  logic to_hit;

  logic              cs;
  logic              rd;
  logic              busy;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  logic        to_flag;

  assign to_hit = (state == WAIT) && !bus.mem_ready
                && (cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      to_flag <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 16'd1;
      if (finish)
        to_flag <= to_hit;
      err0 <= (state == DONE) && !gnt && to_flag;
      err1 <= (state == DONE) && gnt && to_flag;
    end
  end
`else
  logic unused_to;

  assign to_hit    = 1'b0;
  assign err0      = 1'b0;
  assign err1      = 1'b0;
  assign unused_to = |TIMEOUT_CYC;
`endif

  // A port whose ack is still visible is masked so a requester
  // dropping req on that ack cannot get a duplicate grant.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    grant_en = 1'b0;
    finish   = 1'b0;
    req0     = bus.rq0_req && !ack0;
    req1     = bus.rq1_req && !ack1;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_en = 1'b1;
          gnt_nx   = (req0 && req1) ? !last_grant : req1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (bus.mem_ready || to_hit) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes follow the state one edge later, giving cs a
  // two-cycle low gap and ack one edge after DONE is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cs         <= 1'b0;
      rd         <= 1'b0;
      busy       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      cs    <= (state == ISSUE) || (state == WAIT);
      ack0  <= (state == DONE) && !gnt;
      ack1  <= (state == DONE) && gnt;
      if (grant_en) begin
        gnt        <= gnt_nx;
        last_grant <= gnt_nx;
        rd         <= gnt_nx ? bus.rq1_read : bus.rq0_read;
        addr       <= gnt_nx ? bus.rq1_addr : bus.rq0_addr;
        wdata      <= gnt_nx ? bus.rq1_wdata : bus.rq0_wdata;
      end
      if (finish && (rd || to_hit)) begin
        if (gnt)
          rdata1 <= to_hit ? '1 : bus.mem_rdata;
        else
          rdata0 <= to_hit ? '1 : bus.mem_rdata;
      end
    end
  end

  assign bus.mem_cs    = cs;
  assign bus.mem_read  = rd;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.busy      = busy;
  assign bus.gnt_id    = gnt;
  assign bus.rq0_ack   = ack0;
  assign bus.rq1_ack   = ack1;
  assign bus.rq0_rdata = rdata0;
  assign bus.rq1_rdata = rdata1;
  assign bus.rq0_err   = err0;
  assign bus.rq1_err   = err1;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: vector table plus corner sequences.
// Timeout sequence adapts to SPI_ARB_TIMEOUT_EN.
module tb_spi_flash_arbiter;
  localparam int AW = 24;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif();

  spi_flash_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  typedef struct {
    bit          port;
    bit          rd;
    logic [23:0] addr;
    logic [7:0]  wd;
    int          dly;
    logic [7:0]  rin;
    logic [7:0]  exp_r0;
    logic [7:0]  exp_r1;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack0 = 0, n_ack1 = 0, n_err = 0, err_lone = 0, ack_wide = 0;
  bit prev_a0 = 0, prev_a1 = 0, prev_cs = 0, have_fall = 0;
  int low_run = 0, gap_min = 999, gap_max = 0;
  bit order[$];
  bit auto_en = 0;
  int dly = 1, cs_cnt = 0;
  logic [7:0] rin = 8'h00;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample on the falling edge, then play controller.
  task automatic step();
    @(negedge clk);
    if (bif.rq0_ack) begin
      n_ack0++; order.push_back(1'b0);
      if (prev_a0) ack_wide++;
    end
    if (bif.rq1_ack) begin
      n_ack1++; order.push_back(1'b1);
      if (prev_a1) ack_wide++;
    end
    if (bif.rq0_err || bif.rq1_err) n_err++;
    if ((bif.rq0_err && !bif.rq0_ack) || (bif.rq1_err && !bif.rq1_ack))
      err_lone++;
    prev_a0 = bif.rq0_ack;
    prev_a1 = bif.rq1_ack;
    if (bif.mem_cs) begin
      if (!prev_cs && have_fall) begin
        if (low_run < gap_min) gap_min = low_run;
        if (low_run > gap_max) gap_max = low_run;
      end
    end else begin
      if (prev_cs) begin have_fall = 1; low_run = 0; end
      low_run++;
    end
    prev_cs = bif.mem_cs;
    if (!bif.mem_cs) cs_cnt = 0;
    if (auto_en) begin
      if (bif.mem_ready) bif.mem_ready = 1'b0;
      else if (bif.mem_cs) begin
        cs_cnt++;
        if (cs_cnt == dly) begin
          bif.mem_ready = 1'b1;
          bif.mem_rdata = rin;
        end
      end
    end
  endtask

  task automatic drive(input bit p, input bit r, input logic [23:0] a,
                       input logic [7:0] w);
    if (p) begin
      bif.rq1_read = r; bif.rq1_addr = a; bif.rq1_wdata = w;
      bif.rq1_req = 1'b1;
    end else begin
      bif.rq0_read = r; bif.rq0_addr = a; bif.rq0_wdata = w;
      bif.rq0_req = 1'b1;
    end
  endtask

  initial begin
    int a0, a1, lat, cs_hi, bad_busy;
    bit stable, err_at;
    logic [3:0] ord;

    vecs[0] = '{1'b0, 1'b1, 24'h000010, 8'h00, 5, 8'hA5, 8'hA5, 8'h00, 7};
    vecs[1] = '{1'b1, 1'b0, 24'h123456, 8'h3C, 3, 8'h77, 8'hA5, 8'h00, 5};
    vecs[2] = '{1'b1, 1'b1, 24'hABCDEF, 8'h00, 1, 8'h5A, 8'hA5, 8'h5A, 3};
    vecs[3] = '{1'b0, 1'b0, 24'hFFFFFF, 8'hC3, 2, 8'h11, 8'hA5, 8'h5A, 4};
    vecs[4] = '{1'b0, 1'b1, 24'h000000, 8'h00, 4, 8'h00, 8'h00, 8'h5A, 6};
    vecs[5] = '{1'b1, 1'b1, 24'h800001, 8'h00, 2, 8'hFF, 8'h00, 8'hFF, 4};

    bif.rq0_req = 0; bif.rq0_read = 0; bif.rq0_addr = '0; bif.rq0_wdata = '0;
    bif.rq1_req = 0; bif.rq1_read = 0; bif.rq1_addr = '0; bif.rq1_wdata = '0;
    bif.mem_ready = 0; bif.mem_rdata = '0;

    step(); step();
    check("rst_ctrl", 32'({bif.mem_cs, bif.mem_read, bif.busy, bif.rq0_ack,
          bif.rq1_ack, bif.rq0_err, bif.rq1_err, bif.gnt_id}), 0);
    check("rst_addr", 32'(bif.mem_addr), 0);
    check("rst_wdata", 32'(bif.mem_wdata), 0);
    check("rst_rdata0", 32'(bif.rq0_rdata), 0);
    check("rst_rdata1", 32'(bif.rq1_rdata), 0);
    rst = 1'b1;
    step();

    // Single-port transactions from the table
    for (int v = 0; v < 6; v++) begin
      a0 = n_ack0; a1 = n_ack1;
      dly = vecs[v].dly; rin = vecs[v].rin; auto_en = 1;
      drive(vecs[v].port, vecs[v].rd, vecs[v].addr, vecs[v].wd);
      lat = -1; stable = 1; cs_hi = 0;
      for (int i = 1; i <= 300; i++) begin
        step();
        if (bif.mem_cs) begin
          cs_hi++;
          if (bif.mem_addr !== vecs[v].addr || bif.mem_read !== vecs[v].rd ||
              (!vecs[v].rd && bif.mem_wdata !== vecs[v].wd))
            stable = 0;
        end
        if (vecs[v].port ? bif.rq1_ack : bif.rq0_ack) begin
          lat = i - 1;
          break;
        end
      end
      bif.rq0_req = 0; bif.rq1_req = 0;
      step(); step();
      check($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_cs_hi", v), cs_hi, vecs[v].dly + 1);
      check($sformatf("v%0d_stable", v), 32'(stable), 1);
      check($sformatf("v%0d_ack0", v), n_ack0 - a0, vecs[v].port ? 0 : 1);
      check($sformatf("v%0d_ack1", v), n_ack1 - a1, vecs[v].port ? 1 : 0);
      check($sformatf("v%0d_rdata0", v), 32'(bif.rq0_rdata),
            32'(vecs[v].exp_r0));
      check($sformatf("v%0d_rdata1", v), 32'(bif.rq1_rdata),
            32'(vecs[v].exp_r1));
      check($sformatf("v%0d_gnt", v), 32'(bif.gnt_id), 32'(vecs[v].port));
    end

    // Both ports held: round-robin 0,1,0,1 with 2-cycle cs gaps
    order.delete(); gap_min = 999; gap_max = 0; have_fall = 0; ack_wide = 0;
    dly = 3; rin = 8'h40; auto_en = 1;
    bif.rq0_read = 1; bif.rq0_addr = 24'h000100;
    bif.rq1_read = 1; bif.rq1_addr = 24'h000200;
    bif.rq0_req = 1; bif.rq1_req = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (order.size() >= 4) break;
    end
    bif.rq0_req = 0; bif.rq1_req = 0;
    step(); step(); step();
    ord = 4'hF;
    if (order.size() >= 4) ord = {order[0], order[1], order[2], order[3]};
    check("rr_count", order.size(), 4);
    check("rr_order", 32'(ord), 32'(4'b0101));
    check("rr_gap_min", gap_min, 2);
    check("rr_gap_max", gap_max, 2);
    check("rr_ack_width", ack_wide, 0);
    check("rr_rdata0", 32'(bif.rq0_rdata), 32'h40);
    check("rr_rdata1", 32'(bif.rq1_rdata), 32'h40);

    // Stale ready before/through ISSUE, req dropped mid-WAIT
    auto_en = 0; a0 = n_ack0;
    bif.mem_ready = 1; bif.mem_rdata = 8'h99;
    step(); step(); step();
    check("stale_idle_busy", 32'(bif.busy), 0);
    drive(1'b0, 1'b1, 24'h000055, 8'h00);
    step(); step();
    bif.mem_ready = 0;
    step();
    bif.rq0_req = 0;
    step(); step();
    check("stale_no_ack", n_ack0 - a0, 0);
    check("stale_cs", 32'(bif.mem_cs), 1);
    check("stale_busy", 32'(bif.busy), 1);
    bif.mem_ready = 1; bif.mem_rdata = 8'h66;
    step();
    bif.mem_ready = 0;
    step(); step(); step();
    check("drop_ack", n_ack0 - a0, 1);
    check("drop_rdata0", 32'(bif.rq0_rdata), 32'h66);
    check("drop_idle", 32'(bif.busy), 0);

    // Reset during WAIT, then pending rq1 serviced
    a1 = n_ack1;
    drive(1'b1, 1'b1, 24'h000777, 8'h00);
    step(); step(); step(); step();
    #2 rst = 1'b0;
    #1;
    check("arst_cs", 32'(bif.mem_cs), 0);
    check("arst_busy", 32'(bif.busy), 0);
    check("arst_rdata1", 32'(bif.rq1_rdata), 0);
    check("arst_gnt", 32'(bif.gnt_id), 0);
    step(); step();
    rst = 1'b1;
    dly = 2; rin = 8'h3E; auto_en = 1; lat = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (bif.rq1_ack) begin lat = i - 1; break; end
    end
    bif.rq1_req = 0;
    step(); step();
    check("arst_lat", lat, 4);
    check("arst_ack1", n_ack1 - a1, 1);
    check("arst_rdata", 32'(bif.rq1_rdata), 32'h3E);
    check("no_err", n_err, 0);

    // Controller never answers
    auto_en = 0; a0 = n_ack0;
    drive(1'b0, 1'b1, 24'h000042, 8'h00);
`ifdef SPI_ARB_TIMEOUT_EN
    lat = -1; err_at = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (bif.rq0_ack) begin
        lat = i - 1; err_at = bif.rq0_err;
        break;
      end
    end
    bif.rq0_req = 0;
    step(); step();
    check("to_lat", lat, 18);
    check("to_err", 32'(err_at), 1);
    check("to_rdata", 32'(bif.rq0_rdata), 32'hFF);
    check("to_ack", n_ack0 - a0, 1);
    check("to_idle", 32'(bif.busy), 0);
`else
    bad_busy = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!bif.busy) bad_busy++;
    end
    check("hang_busy", bad_busy, 0);
    check("hang_err", n_err, 0);
    check("hang_ack", n_ack0 - a0, 0);
    bif.rq0_req = 0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
`endif
    check("err_lone", err_lone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Two-port arbiter/sequencer that shares one SPI flash controller transaction interface between two requesters, e.g. instruction fetch (port 0) and data/loader (port 1).
- Grants are round-robin, and one transaction is in flight at a time.
- The block drives the controller's chip-select, read/write, address and data inputs, and waits for the controller's ready.
- It returns read data and a one-cycle ack to the granted requester.

Parameters:
- ADDR_W, 24, address width to the flash controller.
- DATA_W, 8, data width.
- TIMEOUT_CYC, 4096, cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rq0_req  in  1  port 0 request; held until rq0_ack.
- rq0_read  in  1  1 = read, 0 = write.
- rq0_addr  in  ADDR_W  port 0 address.
- rq0_wdata  in  DATA_W  port 0 write data.
- rq0_ack  out  1  one-cycle completion pulse.
- rq0_rdata  out  DATA_W  read data; valid with ack, held until next port 0 ack.
- rq0_err  out  1  timeout flag; pulses with ack.
- rq1_req, rq1_read, rq1_addr, rq1_wdata, rq1_ack, rq1_rdata, rq1_err: same as port 0, for port 1.
- mem_cs  out  1  controller chip-select (active-high transaction strobe).
- mem_read  out  1  controller read/write select.
- mem_addr  out  ADDR_W  controller address.
- mem_wdata  out  DATA_W  controller write data.
- mem_ready  in  1  controller completion.
- mem_rdata  in  DATA_W  controller read data; valid while mem_ready = 1.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  port owning the current or last transaction.

Behaviour:
- Reset (rst = 0, asynchronous) values:
  - state = IDLE.
  - mem_cs, mem_read, busy, both acks and both errs = 0.
  - mem_addr, mem_wdata, both rdata = 0.
  - gnt_id = 0; last_grant = 1, so port 0 wins the first tie.
- All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant !last_grant.
  - On grant: latch the port's read/addr/wdata into mem_*, set gnt_id and last_grant, and go to ISSUE at the next edge.
- ISSUE (exactly 1 cycle):
  - mem_cs = 1, busy = 1.
  - mem_ready is ignored here, so a stale ready cannot complete the transaction.
  - Next state is WAIT.
- WAIT:
  - mem_cs stays 1 and mem_* are held stable.
  - When mem_ready = 1, capture mem_rdata into the granted port's rdata (reads only; on writes rdata is unchanged) and go to DONE.
- DONE (exactly 1 cycle):
  - mem_cs = 0.
  - Granted port's ack = 1; its err = 1 only on timeout.
  - Next state is IDLE.
  - Minimum cs-low gap between transactions is 2 cycles (DONE + IDLE).
- Latency: the req-high sample edge is cycle 0 → mem_cs rises at edge 1. mem_ready sampled at edge k → ack high during the cycle after edge k+1. Minimum req-to-ack is 3 edges.
- Requester rules:
  - A requester dropping req before ack does not abort; the transaction completes and ack still pulses.
  - Keeping req high after ack issues another transaction. Round-robin alternates grants while both ports request, so neither starves (service ratio 1:1).
- No request is lost: a request arriving while busy is serviced once the state returns to IDLE.
- Reset mid-transaction immediately drops mem_cs and returns to IDLE; no ack is issued.
- mem_ready asserted outside WAIT has no effect.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC - 1 without mem_ready, go to DONE.
  - In that case the granted rdata is forced to all-ones, ack pulses, and err pulses with it.
  - mem_ready and timeout in the same cycle: ready wins, err = 0.
- When not defined:
  - No counter is synthesized; WAIT lasts until mem_ready.
  - rq0_err and rq1_err are tied 0 (the ports still exist).

Test Plan:
1. Reset with rst = 0 → all outputs 0, gnt_id = 0. Release, then rq0 read addr 0x000010; mem_ready pulses at WAIT cycle 5 with mem_rdata = 0xA5 → mem_cs high from edge 1 through the ready edge, rq0_ack single pulse, rq0_rdata = 0xA5, rq1_ack never set.
2. rq0 and rq1 both asserted at the same edge and held for 4 transactions, controller ready after 3 cycles → grant order 0,1,0,1; mem_cs low for 2 cycles between each; each ack is exactly one cycle.
3. rq1 write addr 0x123456, wdata 0x3C → mem_read = 0, mem_addr = 0x123456, mem_wdata = 0x3C stable through WAIT; rq1_rdata unchanged; rq1_ack pulses.
4. mem_ready held high before the request and during ISSUE, then dropped and re-pulsed in WAIT → completion only on the WAIT pulse. Also: rq0_req dropped mid-WAIT → rq0_ack still pulses.
5. rst pulsed low during WAIT → mem_cs = 0 and busy = 0 asynchronously; no ack. After release, a pending rq1 is serviced normally.
6. With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYC = 16, mem_ready never asserted → ack and err pulse together after 16 WAIT cycles, rdata = 0xFF. Without the macro, the same stimulus leaves busy = 1 for 200 cycles with err = 0.
